// File: rtl/rn_tb_pkg.sv
// rtl/rn_tb_pkg.sv - shared types and constants for the testbench packet sink
package rn_tb_pkg;

  // Sink state: wait for enable, accept packets, hold after the expected count
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Bit positions inside err_flags
  localparam int ERR_KEEP_ZERO       = 0;
  localparam int ERR_KEEP_NONCONTIG  = 1;
  localparam int ERR_PARTIAL_NONLAST = 2;
  localparam int ERR_SIZE_CHANGE     = 3;
  localparam int ERR_SIZE_MISMATCH   = 4;
  localparam int ERR_EXTRA_VALID     = 5;
  localparam int ERR_W               = 6;

endpackage

// File: rtl/rn_axis_keep_check.sv
// rtl/rn_axis_keep_check.sv - combinational tkeep classifier (popcount, zero, contiguous, full)
module rn_axis_keep_check #(
  parameter int AXIS_KEEP_WIDTH = 64
) (
  input  logic [AXIS_KEEP_WIDTH-1:0]       tkeep,
  output logic [$clog2(AXIS_KEEP_WIDTH):0] popcount,
  output logic                             is_zero,
  output logic                             is_contig,
  output logic                             is_full
);

  localparam int POP_W = $clog2(AXIS_KEEP_WIDTH) + 1;

  // Count enabled bytes in the beat
  always_comb begin
    popcount = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      popcount = popcount + POP_W'(tkeep[i]);
    end
  end

  // A contiguous low-aligned mask plus one has no bits in common with itself
  assign is_zero   = (tkeep == '0);
  assign is_contig = ((tkeep & (tkeep + AXIS_KEEP_WIDTH'(1))) == '0);
  assign is_full   = &tkeep;

endmodule

// File: rtl/rn_tb_axis_pkt_checker.sv
// rtl/rn_tb_axis_pkt_checker.sv - AXI-Stream sink with backpressure pattern and per-packet framing checks
module rn_tb_axis_pkt_checker
  import rn_tb_pkg::*;
#(
  parameter int          AXIS_DATA_WIDTH = 512,
  parameter int          AXIS_KEEP_WIDTH = 64,
  parameter int          USER_SIZE_WIDTH = 16,
  parameter logic [31:0] READY_PATTERN   = 32'hFFFF_FFFF
) (
  input  logic                       axis_clk,
  input  logic                       axis_rstn,
  input  logic                       enable,
  input  logic [63:0]                num_pkts,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
  output logic                       s_axis_tready,
  output logic [63:0]                pkt_cnt,
  output logic [63:0]                beat_cnt,
  output logic [63:0]                byte_cnt,
  output logic [USER_SIZE_WIDTH-1:0] last_pkt_len,
  output logic [ERR_W-1:0]           err_flags,
  output logic                       all_received
);

  localparam int POP_W = $clog2(AXIS_KEEP_WIDTH) + 1;
  localparam int ACC_W = USER_SIZE_WIDTH + 1;
  localparam int SUM_W = ACC_W + 1;

  chk_state_t                 state;
  logic [31:0]                pat;
  logic [63:0]                exp_pkts;
  logic                       in_pkt;
  logic [USER_SIZE_WIDTH-1:0] exp_size;
  logic [ACC_W-1:0]           acc;

  logic [POP_W-1:0]           kc_pop;
  logic                       kc_zero;
  logic                       kc_contig;
  logic                       kc_full;

  logic                       hs;
  logic                       first_beat;
  logic [ACC_W-1:0]           acc_base;
  logic [SUM_W-1:0]           acc_sum;
  logic [ACC_W-1:0]           acc_total;
  logic [USER_SIZE_WIDTH-1:0] ref_size;
  logic                       last_pkt_done;
  logic [ERR_W-1:0]           beat_err;
  logic                       unused_tdata;

  rn_axis_keep_check #(
    .AXIS_KEEP_WIDTH(AXIS_KEEP_WIDTH)
  ) u_keep_check (
    .tkeep    (s_axis_tkeep),
    .popcount (kc_pop),
    .is_zero  (kc_zero),
    .is_contig(kc_contig),
    .is_full  (kc_full)
  );

  // Payload is carried only for waveform inspection
  assign unused_tdata = ^s_axis_tdata;

  assign s_axis_tready = (state == RUN) & pat[0];
  assign all_received  = (state == DONE);
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign first_beat    = ~in_pkt;

  // Running byte total including this beat, saturating instead of wrapping
  assign acc_base  = first_beat ? '0 : acc;
  assign acc_sum   = {1'b0, acc_base} + SUM_W'(kc_pop);
  assign acc_total = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign ref_size  = first_beat ? s_axis_tuser_size : exp_size;

  assign last_pkt_done = hs & s_axis_tlast & ((pkt_cnt + 64'd1) == exp_pkts);

  // Framing violations raised by the current cycle
  always_comb begin
    beat_err = '0;
    if (hs) begin
      beat_err[ERR_KEEP_ZERO]       = kc_zero;
      beat_err[ERR_KEEP_NONCONTIG]  = ~kc_contig;
      beat_err[ERR_PARTIAL_NONLAST] = ~s_axis_tlast & ~kc_full;
      beat_err[ERR_SIZE_CHANGE]     = ~first_beat & (s_axis_tuser_size != exp_size);
      beat_err[ERR_SIZE_MISMATCH]   = s_axis_tlast & (acc_total != {1'b0, ref_size});
    end
    beat_err[ERR_EXTRA_VALID] = (state == DONE) & s_axis_tvalid;
  end

  // Sink state machine and backpressure pattern rotation
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state    <= IDLE;
      pat      <= READY_PATTERN;
      exp_pkts <= '0;
    end else begin
      if (state == RUN) begin
        pat <= {pat[0], pat[31:1]};
      end
      case (state)
        IDLE: begin
          if (enable) begin
            exp_pkts <= num_pkts;
            state    <= (num_pkts == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_pkt_done) begin
            state <= DONE;
          end else if (!enable && (hs ? s_axis_tlast : !in_pkt)) begin
            state <= IDLE;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-packet tracking, running counters and sticky error flags
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      in_pkt       <= 1'b0;
      exp_size     <= '0;
      acc          <= '0;
      pkt_cnt      <= '0;
      beat_cnt     <= '0;
      byte_cnt     <= '0;
      last_pkt_len <= '0;
      err_flags    <= '0;
    end else begin
      err_flags <= err_flags | beat_err;
      if (hs) begin
        beat_cnt <= beat_cnt + 64'd1;
        byte_cnt <= byte_cnt + 64'(kc_pop);
        if (first_beat) begin
          exp_size <= s_axis_tuser_size;
        end
        if (s_axis_tlast) begin
          pkt_cnt      <= pkt_cnt + 64'd1;
          last_pkt_len <= acc_total[USER_SIZE_WIDTH-1:0];
          in_pkt       <= 1'b0;
          acc          <= '0;
        end else begin
          in_pkt <= 1'b1;
          acc    <= acc_total;
        end
      end
    end
  end

endmodule
